// File: rtl/mips_pkg.sv
// Shared MIPS decode types: opcode constants, immediate extension modes and
// the decoded-entry record held by the decode-stage buffer.
package mips_pkg;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_UPPER = 2'b10
    } ext_mode_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm_ext;
        ext_mode_t   ext_mode;
        logic [31:0] pc;
    } dec_entry_t;

endpackage

// File: rtl/imm_extend_unit.sv
// Combinational immediate extender: picks zero, sign or upper-half extension
// of the 16-bit immediate from the opcode.
module imm_extend_unit
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [15:0] imm16,
    output ext_mode_t   ext_mode,
    output logic [31:0] imm_ext
);

    always_comb begin
        ext_mode = EXT_SIGN;
        imm_ext  = {{16{imm16[15]}}, imm16};
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: begin
                ext_mode = EXT_ZERO;
                imm_ext  = {16'h0000, imm16};
            end
            OP_LUI: begin
                ext_mode = EXT_UPPER;
                imm_ext  = {imm16, 16'h0000};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_decode_reg.sv
// Registered decode stage with a two-entry skid buffer, flush and an
// accepted-instruction counter.
//
// state     | meaning
// ----------+-------------------------------------------
// BUF_EMPTY | no entry held, out_valid low
// BUF_ONE   | main register valid, drives outputs
// BUF_TWO   | main and skid valid, input stalled
module instr_decode_reg
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_shamt,
    output logic [5:0]       out_funct,
    output logic [31:0]      out_imm_ext,
    output logic [1:0]       out_ext_mode,
    output logic [31:0]      out_pc,
    output logic [CNT_W-1:0] inst_count
);

    buf_state_t       state_q, state_d;
    dec_entry_t       main_q, skid_q, new_entry;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, drain;
    logic             load_main, load_skid, move_skid;
    ext_mode_t        new_mode;
    logic [31:0]      new_imm;

    imm_extend_unit u_ext (
        .opcode   (in_instr[31:26]),
        .imm16    (in_instr[15:0]),
        .ext_mode (new_mode),
        .imm_ext  (new_imm)
    );

    always_comb begin
        new_entry.opcode   = in_instr[31:26];
        new_entry.rs       = in_instr[25:21];
        new_entry.rt       = in_instr[20:16];
        new_entry.rd       = in_instr[15:11];
        new_entry.shamt    = in_instr[10:6];
        new_entry.funct    = in_instr[5:0];
        new_entry.imm_ext  = new_imm;
        new_entry.ext_mode = new_mode;
        new_entry.pc       = in_pc;
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = (state_q != BUF_EMPTY) & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != BUF_TWO);
        end
    end

    // Flush overrides every accept/drain decision; only the counter sees the accept.
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (accept) begin
                    state_d   = BUF_ONE;
                    load_main = 1'b1;
                end
                BUF_ONE: begin
                    if (accept && !drain) begin
                        state_d   = BUF_TWO;
                        load_skid = 1'b1;
                    end else if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (drain) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: if (drain) begin
                    state_d   = BUF_ONE;
                    move_skid = 1'b1;
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid    = (state_q != BUF_EMPTY);
        in_ready     = in_ready_q;
        out_opcode   = main_q.opcode;
        out_rs       = main_q.rs;
        out_rt       = main_q.rt;
        out_rd       = main_q.rd;
        out_shamt    = main_q.shamt;
        out_funct    = main_q.funct;
        out_imm_ext  = main_q.imm_ext;
        out_ext_mode = main_q.ext_mode;
        out_pc       = main_q.pc;
        inst_count   = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (load_main)
                main_q <= new_entry;
            else if (move_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= new_entry;
            if (accept)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_decode_reg.sv
// Randomised scoreboard bench for instr_decode_reg against a queue-based
// model of the decode stage.
module tb_instr_decode_reg;

    localparam int CW = 4;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [1:0]  mode;
        logic [31:0] pc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_instr = '0;
    logic [31:0]   in_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [5:0]    out_opcode;
    logic [4:0]    out_rs, out_rt, out_rd, out_shamt;
    logic [5:0]    out_funct;
    logic [31:0]   out_imm_ext;
    logic [1:0]    out_ext_mode;
    logic [31:0]   out_pc;
    logic [CW-1:0] inst_count;

    int total = 0;
    int bad = 0;

    exp_t          q[$];
    exp_t          pend_entry;
    bit            pend_push = 0, pend_flush = 0, pend_cnt = 0;
    logic [CW-1:0] exp_cnt = '0;

    instr_decode_reg #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_shamt(out_shamt), .out_funct(out_funct),
        .out_imm_ext(out_imm_ext), .out_ext_mode(out_ext_mode),
        .out_pc(out_pc), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int unsigned lo;
        lo = w & 32'hFFFF;
        e.opcode = w[31:26];
        e.rs = w[25:21];
        e.rt = w[20:16];
        e.rd = w[15:11];
        e.shamt = w[10:6];
        e.funct = w[5:0];
        e.pc = pc;
        if (e.opcode >= 6'h0C && e.opcode <= 6'h0E) begin
            e.mode = 2'd0;
            e.imm = lo;
        end else if (e.opcode == 6'h0F) begin
            e.mode = 2'd2;
            e.imm = lo * 65536;
        end else begin
            e.mode = 2'd1;
            e.imm = (lo >= 32768) ? (lo + 32'hFFFF0000) : lo;
        end
        return e;
    endfunction

    // Monitor: compares outputs with the model, then commits this cycle's events.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            pend_push = 0;
            pend_flush = 0;
            pend_cnt = 0;
            exp_cnt = '0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("inst_count", 32'(inst_count), 32'(exp_cnt));
            if (q.size() > 0) begin
                chk("opcode", 32'(out_opcode), 32'(q[0].opcode));
                chk("rs", 32'(out_rs), 32'(q[0].rs));
                chk("rt", 32'(out_rt), 32'(q[0].rt));
                chk("rd", 32'(out_rd), 32'(q[0].rd));
                chk("shamt", 32'(out_shamt), 32'(q[0].shamt));
                chk("funct", 32'(out_funct), 32'(q[0].funct));
                chk("imm_ext", out_imm_ext, q[0].imm);
                chk("ext_mode", 32'(out_ext_mode), 32'(q[0].mode));
                chk("pc", out_pc, q[0].pc);
            end
            if (pend_flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (pend_push) q.push_back(pend_entry);
            end
            if (pend_cnt) exp_cnt = exp_cnt + 1'b1;
            pend_push = 0;
            pend_flush = 0;
            pend_cnt = 0;
        end
    end

    // Stimulus: drive one cycle's inputs just after the edge and record the accept.
    task automatic cyc(input bit v, input logic [31:0] w, input logic [31:0] pc,
                       input bit rdy, input bit fl);
        @(posedge clk);
        #1;
        in_valid = v;
        in_instr = w;
        in_pc = pc;
        out_ready = rdy;
        flush = fl;
        pend_flush = fl;
        pend_cnt = v && (q.size() < 2);
        pend_push = pend_cnt && !fl;
        pend_entry = decode(w, pc);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[31:26] = 6'h0C + 6'($urandom_range(0, 3));
            1: w[31:26] = 6'h08;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imm", out_imm_ext, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_mode", 32'(out_ext_mode), 32'd0);
        chk("rst_cnt", 32'(inst_count), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        cyc(1, 32'h34018001, 32'h0000_0040, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("ori_imm", out_imm_ext, 32'h0000_8001);
        chk("ori_mode", 32'(out_ext_mode), 32'd0);
        chk("ori_rt", 32'(out_rt), 32'd1);
        chk("ori_rs", 32'(out_rs), 32'd0);
        chk("ori_pc", out_pc, 32'h40);
        cyc(1, 32'h20018001, 32'h44, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("addi_imm", out_imm_ext, 32'hFFFF_8001);
        chk("addi_mode", 32'(out_ext_mode), 32'd1);
        cyc(1, 32'h3C011234, 32'h48, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("lui_imm", out_imm_ext, 32'h1234_0000);
        chk("lui_mode", 32'(out_ext_mode), 32'd2);

        // back-pressure: A, B accepted, C held until drain
        cyc(1, 32'h2001000A, 32'h100, 0, 0);
        cyc(1, 32'h2001000B, 32'h104, 0, 0);
        cyc(1, 32'h2001000C, 32'h108, 0, 0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        cyc(1, 32'h2001000C, 32'h108, 1, 0);
        cyc(1, 32'h2001000C, 32'h108, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);

        // flush while TWO with in_valid, then flush in ONE with a dropped accept
        cyc(1, 32'h34020001, 32'h200, 0, 0);
        cyc(1, 32'h34020002, 32'h204, 0, 0);
        cyc(1, 32'h34020003, 32'h208, 1, 1);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        cyc(1, 32'h34020004, 32'h20C, 0, 0);
        cyc(1, 32'h34020005, 32'h210, 0, 1);
        cyc(0, 32'h0, 32'h0, 1, 0);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, rnd_word(), $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

        // asynchronous reset between edges mid-stream
        cyc(1, 32'h2003FFFF, 32'h300, 0, 0);
        cyc(1, 32'h20030001, 32'h304, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_cnt", 32'(inst_count), 32'd0);
        in_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        cyc(1, 32'h3C01ABCD, 32'h400, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("post_rst_imm", out_imm_ext, 32'hABCD_0000);
        chk("post_rst_pc", out_pc, 32'h400);
        for (int i = 0; i < 16; i++)
            cyc(1, rnd_word(), 32'h500 + 32'(i * 4), 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("cnt_wrap", 32'(inst_count), 32'd1);
        cyc(0, 32'h0, 32'h0, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_decode_reg.md
# instr_decode_reg

Registered decode stage between instruction fetch and the execute-side operand logic of the MIPS core. It accepts 32-bit instruction words over a valid/ready handshake and splits them into register/function fields. It also produces the 32-bit extended immediate (zero, sign or upper-half) that feeds the ALU operand mux. A two-entry skid buffer keeps full throughput under downstream back-pressure, and a flush input squashes in-flight words on branch redirect.

## Interface
Parameters:
- CNT_W, 16, width of the accepted-instruction counter

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of both buffer entries
- in_valid  in  1  fetch presents a word
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  address of in_instr
- out_valid  out  1  decoded word available
- out_ready  in  1  consumer accepts
- out_opcode  out  6  instr[31:26]
- out_rs, out_rt, out_rd  out  5 each  instr[25:21], [20:16], [15:11]
- out_shamt  out  5  instr[10:6]
- out_funct  out  6  instr[5:0]
- out_imm_ext  out  32  extended immediate
- out_ext_mode  out  2  00 zero, 01 sign, 10 upper (lui), 11 unused
- out_pc  out  32  registered in_pc
- inst_count  out  CNT_W  count of words accepted on the input handshake

## Operation
- Extension is decided from the opcode at accept time and stored with the entry:
  - opcode 0x0C/0x0D/0x0E (andi/ori/xori): mode 00, imm_ext = {16'h0, instr[15:0]}.
  - opcode 0x0F (lui): mode 10, imm_ext = {instr[15:0], 16'h0}.
  - All other opcodes: mode 01, imm_ext = {16{instr[15]}, instr[15:0]}.
- Storage is a main register (drives the outputs) plus one skid register.
- Buffer states:
  - EMPTY: no entry held.
  - ONE: main register valid.
  - TWO: main and skid both valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + no drain -> TWO; the new word goes to skid.
  - ONE + accept + drain -> ONE; the new word replaces main.
  - ONE + drain only -> EMPTY.
  - TWO + drain -> ONE; skid moves to main. No accept is possible in TWO.
- Handshake rules:
  - in_ready = state != TWO. It is registered, so it never depends combinationally on out_ready.
  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
  - out_valid = state != EMPTY.
  - Outputs stay stable while out_valid & !out_ready.
- Words are delivered in order, with no loss or duplication.
- inst_count increments by 1 on every accept and wraps from 2^CNT_W-1 to 0. It is not cleared by flush.
- Flush:
  - next state = EMPTY.
  - An accept or drain in the same cycle is discarded; the counter still increments for that accept.
  - Flush has priority over all other events.
- Reset values:
  - state EMPTY, out_valid 0, in_ready 1.
  - All field outputs, out_imm_ext, out_pc and inst_count are 0; out_ext_mode is 00.

## Timing
- Latency: a word accepted in cycle N is on the outputs with out_valid=1 in cycle N+1.
- Throughput: one word per cycle while out_ready=1.
- in_ready falls the cycle after the state enters TWO. It rises the cycle after the drain that leaves TWO.
- After flush in cycle N: out_valid=0 and in_ready=1 in cycle N+1.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronous). The first accept is possible on the first rising edge after rst_n deasserts.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_ANDI, OP_ORI, OP_XORI, OP_LUI;
  - ext_mode_t enum (EXT_ZERO, EXT_SIGN, EXT_UPPER);
  - the decoded-entry struct (fields, imm_ext, ext_mode, pc).
- One sub-module, imm_extend_unit: combinational opcode + imm16 -> {ext_mode, imm_ext}, instantiated once on the input path.

## Test plan
- ori 0x34018001 at pc 0x0000_0040, out_ready=1:
  - cycle+1: out_imm_ext=0x0000_8001, mode 00, rt=1, rs=0, out_pc=0x40.
- addi 0x20018001 -> out_imm_ext=0xFFFF_8001, mode 01. lui 0x3C011234 -> out_imm_ext=0x1234_0000, mode 10.
- Back-pressure:
  - Stream words A, B, C with out_ready=0: A and B are accepted and in_ready=0 from the following cycle; C is held.
  - Raise out_ready: outputs show A, B, C on consecutive cycles, in order.
- Flush while in TWO, with in_valid=1 that cycle:
  - next cycle out_valid=0, in_ready=1; no stale word ever appears.
  - inst_count includes the dropped accept.
- Counter wrap with CNT_W=4: 17 accepts -> inst_count=1.
- Reset:
  - Assert rst_n=0 mid-stream between clock edges: out_valid drops to 0 at once and in_ready=1.
  - After release, the first word decodes correctly.
